store_fwd_buffer: RTL and testbench
===================================

Name: store_fwd_buffer

Overview:
Posted store buffer between the MEM stage and data memory. It accepts retiring stores, drains them to data memory in order, and forwards buffered store data to younger loads. It is the store-to-load counterpart of the existing load-to-store forwarding path. Loads that partially overlap a buffered store are stalled until that store has drained.

Parameters:
DEPTH, 4, number of buffer entries; must be a power of two and at least 2.
AW, 32, byte-address width. Data width is fixed at 32 bits.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
st_valid  in  1  MEM-stage store request
st_ready  out  1  buffer can accept a store
st_addr  in  AW  store byte address; bits [1:0] are ignored
st_data  in  32  store data, already lane-aligned
st_be  in  4  store byte enables
ld_valid  in  1  MEM-stage load lookup
ld_addr  in  AW  load byte address; bits [1:0] are ignored
ld_be  in  4  load byte lanes required
ld_hit  out  1  load is fully satisfied from the buffer
ld_data  out  32  forwarded data; lanes outside ld_be are 0
ld_stall  out  1  partial overlap; MEM stage must hold the load
dm_wvalid  out  1  drain request to data memory
dm_waddr  out  AW  drain address, with bits [1:0] = 0
dm_wdata  out  32  drain data
dm_wbe  out  4  drain byte enables
dm_wready  in  1  data memory accepts the drain request
empty  out  1  buffer holds no entries
count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: circular FIFO with head pointer, tail pointer and count. Each entry holds addr[AW-1:2], data and be.
- Reset (asynchronous, rst=1): head=0, tail=0, count=0, all entry valid bits cleared.
  - Outputs during and after reset: st_ready=1, empty=1, dm_wvalid=0, ld_hit=0, ld_stall=0, ld_data=0, count=0.
- Enqueue: when st_valid && st_ready at a clock edge, write the entry at tail and increment tail modulo DEPTH.
  - st_ready = (count != DEPTH). It is registered-state based; a same-cycle drain does not free space for the same cycle.
  - A store with st_be=0 is still enqueued and drained; it never matches any load.
- Drain:
  - dm_wvalid = (count != 0).
  - dm_waddr, dm_wdata and dm_wbe present the head entry combinationally from registered state.
  - On dm_wvalid && dm_wready, pop the head and increment head modulo DEPTH.
  - Drain order is strictly FIFO.
  - Head fields must stay stable while dm_wvalid=1 and dm_wready=0.
- Simultaneous enqueue and drain in one cycle: count is unchanged, and both pointers advance.
- Load lookup is combinational over registered entries only. A store enqueued in the same cycle is not visible to that cycle's lookup.
  - Match: the entry is valid, entry.addr == ld_addr[AW-1:2], and (entry.be & ld_be) != 0.
  - Only the youngest matching entry, nearest tail, is used.
  - Hit: ld_valid, a match exists, and (ld_be & ~youngest.be) == 0. Then ld_hit=1, ld_stall=0, and ld_data = youngest.data masked by ld_be.
  - Partial: ld_valid, a match exists, but coverage is incomplete. Then ld_hit=0 and ld_stall=1.
    - Older entries are never merged.
    - The stall clears once the matching entry drains and no other entry matches.
  - Miss or ld_valid=0: ld_hit=0, ld_stall=0, ld_data=0. The load then reads data memory.
- Wrap-around: pointers wrap modulo DEPTH. Youngest-first priority is computed relative to tail, not by physical index.
- Full: st_ready=0. The upstream holds st_* stable, and an asserted st_valid is ignored until space frees.
- Empty: dm_wvalid=0, empty=1, and no load ever hits or stalls.
- Reset asserted mid-operation: all buffered stores are discarded immediately, with no drain. dm_wvalid falls asynchronously.
- No combinational path from dm_wready to st_ready, ld_hit or ld_stall.

Test Plan:
- Reset then idle -> st_ready=1, empty=1, dm_wvalid=0, count=0.
- With dm_wready=0, enqueue 4 stores to 0x100, 0x104, 0x108 and 0x10C, each with be=4'hF -> count=4, st_ready=0; a fifth st_valid is not accepted.
- Drain ordering:
  - Release dm_wready=1 -> dm_waddr sequence is 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - Afterwards empty=1.
- Youngest-wins forwarding:
  - With dm_wready=0, store 0x200 data=0x11111111 be=F, then store 0x200 data=0x22222222 be=F.
  - A load at 0x200 with be=F -> ld_hit=1, ld_data=0x22222222.
- Partial overlap:
  - Store 0x300 be=4'b0011 data=0x0000ABCD.
  - A load at 0x300 with be=F -> ld_stall=1, ld_hit=0.
  - Assert dm_wready until that entry drains -> ld_stall=0, ld_hit=0.
  - A load at 0x300 with be=4'b0001 instead -> ld_hit=1, ld_data=0x000000CD.
- Simultaneous push and pop at count=2, then wrap:
  - Push and pop in the same cycle -> count stays 2.
  - Run 10 mixed cycles with the pointers wrapping -> drain order matches enqueue order.
  - Assert rst mid-stream -> count=0 and dm_wvalid=0 immediately.

Source files
------------

// File: rtl/store_fwd_buffer.sv
`timescale 1ns/1ps
// store_fwd_buffer
// Posted store buffer sitting between the MEM stage and data memory.
// Retiring stores are queued in a circular FIFO, drained to data memory in
// order, and forwarded to younger loads that are fully covered by the
// youngest matching store. Loads that only partially overlap the youngest
// matching store are stalled until that store drains (no merging).
// DEPTH must be a power of two and at least 2.
module store_fwd_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  // store enqueue
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_data,
  input  logic [3:0]             st_be,
  // load lookup
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_addr,
  input  logic [3:0]             ld_be,
  output logic                   ld_hit,
  output logic [31:0]            ld_data,
  output logic                   ld_stall,
  // drain port
  output logic                   dm_wvalid,
  output logic [AW-1:0]          dm_waddr,
  output logic [31:0]            dm_wdata,
  output logic [3:0]             dm_wbe,
  input  logic                   dm_wready,
  // status
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage: word address, lane-aligned data and byte enables.
  logic [AW-3:0]    ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [3:0]       ent_be   [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  logic push;
  logic pop;

  // Sub-word address bits carry no information for word-granular matching.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // Handshakes are derived from registered occupancy only, so dm_wready
  // never reaches st_ready or the load lookup combinationally.
  assign st_ready  = (cnt != CW'(DEPTH));
  assign dm_wvalid = (cnt != '0);
  assign empty     = (cnt == '0);
  assign count     = cnt;

  assign push = st_valid && st_ready;
  assign pop  = dm_wvalid && dm_wready;

  // Head entry is presented straight from the registers; it cannot change
  // while a drain is pending because only a pop moves head.
  assign dm_waddr = {ent_addr[head], 2'b00};
  assign dm_wdata = ent_data[head];
  assign dm_wbe   = ent_be[head];

  // Pointer, occupancy and valid-bit bookkeeping; reset discards everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
      // head and tail can only coincide when empty (no pop) or full (no
      // push), so clearing then setting never collides on one slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && (head == PW'(i))) begin
          ent_valid[i] <= 1'b0;
        end
        if (push && (tail == PW'(i))) begin
          ent_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Payload write at the tail slot; payload needs no reset since the valid
  // bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr[AW-1:2];
      ent_data[tail] <= st_data;
      ent_be[tail]   <= st_be;
    end
  end

  // Per-slot match against the load: same word and at least one shared lane.
  // A store with no enabled lanes therefore never matches.
  logic [DEPTH-1:0] slot_match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign slot_match[gi] = ent_valid[gi]
                            && (ent_addr[gi] == ld_addr[AW-1:2])
                            && ((ent_be[gi] & ld_be) != 4'b0000);
    end
  endgenerate

  logic          y_found;
  logic [31:0]   y_data;
  logic [3:0]    y_be;
  logic [PW-1:0] y_idx;

  // Youngest-first search, walking backwards from the slot just before tail
  // so priority follows age rather than physical slot number.
  always_comb begin
    y_found = 1'b0;
    y_data  = '0;
    y_be    = '0;
    y_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      y_idx = tail - PW'(k + 1);
      if (!y_found && slot_match[y_idx]) begin
        y_found = 1'b1;
        y_data  = ent_data[y_idx];
        y_be    = ent_be[y_idx];
      end
    end
  end

  logic        full_cover;
  logic [31:0] lane_mask;

  // Expand the requested lanes to a bit mask for the forwarded word.
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < 4; b++) begin
      lane_mask[b*8 +: 8] = {8{ld_be[b]}};
    end
  end

  assign full_cover = ((ld_be & ~y_be) == 4'b0000);

  // Hit only when the youngest match alone covers every requested lane;
  // otherwise the load must wait for that store to drain.
  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    if (ld_valid && y_found) begin
      if (full_cover) begin
        ld_hit  = 1'b1;
        ld_data = y_data & lane_mask;
      end else begin
        ld_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_fwd_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for store_fwd_buffer: stimulus pushes expected drains and
// expected load responses; a negedge monitor pops and compares them.
module tb_store_fwd_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [3:0]    ld_be;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic          ld_stall;
  logic          dm_wvalid;
  logic [AW-1:0] dm_waddr;
  logic [31:0]   dm_wdata;
  logic [3:0]    dm_wbe;
  logic          dm_wready;
  logic          empty;
  logic [2:0]    count;

  store_fwd_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_be(st_be),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .dm_wvalid(dm_wvalid), .dm_waddr(dm_waddr), .dm_wdata(dm_wdata),
    .dm_wbe(dm_wbe), .dm_wready(dm_wready),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } drain_t;

  typedef struct {
    logic        hit;
    logic        stall;
    logic [31:0] data;
  } ldexp_t;

  drain_t dq[$];
  ldexp_t lq[$];

  int total = 0;
  int bad   = 0;
  int model_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    drain_t e;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    e.addr = {a[31:2], 2'b00};
    e.data = d;
    e.be   = be;
    dq.push_back(e);
    step();
    st_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] be,
                      input logic h, input logic s, input logic [31:0] d);
    ldexp_t e;
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_be    = be;
    e.hit   = h;
    e.stall = s;
    e.data  = d;
    lq.push_back(e);
    step();
    ld_valid = 1'b0;
  endtask

  task automatic drain_all();
    dm_wready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (empty) break;
      step();
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_leftover", 32'(dq.size()), 32'd0);
    dm_wready = 1'b0;
  endtask

  // Monitor: compares every drain handshake and every load lookup
  // against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && dm_wvalid && dm_wready) begin
      if (dq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL drain_unexpected: got addr=%h expected no drain", dm_waddr);
      end else begin
        drain_t e;
        e = dq.pop_front();
        check("drain_addr", dm_waddr, e.addr);
        check("drain_data", dm_wdata, e.data);
        check("drain_be", 32'(dm_wbe), 32'(e.be));
      end
    end
    if (!rst && ld_valid) begin
      if (lq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL load_unexpected: got ld_valid with no expectation");
      end else begin
        ldexp_t e;
        e = lq.pop_front();
        check("ld_hit", 32'(ld_hit), 32'(e.hit));
        check("ld_stall", 32'(ld_stall), 32'(e.stall));
        check("ld_data", ld_data, e.data);
      end
    end
  end

  logic [9:0] sv_pat;
  logic [9:0] wr_pat;

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_be = '0; dm_wready = 1'b0;
    #1;
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_wvalid", 32'(dm_wvalid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ld_hit", 32'(ld_hit), 32'd0);
    check("rst_ld_stall", 32'(ld_stall), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    step(); step();
    rst = 1'b0;
    step(); step();
    check("idle_st_ready", 32'(st_ready), 32'd1);
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_wvalid", 32'(dm_wvalid), 32'd0);
    check("idle_count", 32'(count), 32'd0);

    // Fill to capacity with drain blocked, then try a fifth store.
    store(32'h100, 32'hA0000000, 4'hF);
    store(32'h104, 32'hA0000001, 4'hF);
    store(32'h108, 32'hA0000002, 4'hF);
    store(32'h10C, 32'hA0000003, 4'hF);
    check("full_count", 32'(count), 32'd4);
    check("full_st_ready", 32'(st_ready), 32'd0);
    st_valid = 1'b1; st_addr = 32'h110; st_data = 32'hDEADBEEF; st_be = 4'hF;
    step(); step();
    check("full_reject_count", 32'(count), 32'd4);
    st_valid = 1'b0;

    // One drain per cycle once released, in enqueue order.
    dm_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_seq_count", 32'(count), 32'(3 - i));
    end
    dm_wready = 1'b0;
    check("drained_empty", 32'(empty), 32'd1);

    // Youngest store to the same word wins.
    store(32'h200, 32'h11111111, 4'hF);
    store(32'h200, 32'h22222222, 4'hF);
    load(32'h200, 4'hF, 1'b1, 1'b0, 32'h22222222);
    load(32'h200, 4'b0100, 1'b1, 1'b0, 32'h00220000);
    load(32'h204, 4'hF, 1'b0, 1'b0, 32'h0);
    drain_all();

    // Partial overlap stalls until the store drains.
    store(32'h300, 32'h0000ABCD, 4'b0011);
    load(32'h300, 4'hF, 1'b0, 1'b1, 32'h0);
    load(32'h300, 4'b0001, 1'b1, 1'b0, 32'h000000CD);
    load(32'h300, 4'b1100, 1'b0, 1'b0, 32'h0);
    dm_wready = 1'b1;
    step();
    dm_wready = 1'b0;
    check("partial_drained", 32'(empty), 32'd1);
    load(32'h300, 4'hF, 1'b0, 1'b0, 32'h0);

    // No merge with older entries; non-overlapping younger entry is skipped;
    // a zero-enable store never matches.
    store(32'h500, 32'hAAAAAAAA, 4'hF);
    store(32'h500, 32'h000000BB, 4'b0001);
    store(32'h400, 32'h12345678, 4'b0000);
    load(32'h500, 4'hF, 1'b0, 1'b1, 32'h0);
    load(32'h500, 4'b0001, 1'b1, 1'b0, 32'h000000BB);
    load(32'h500, 4'b0010, 1'b1, 1'b0, 32'h0000AA00);
    load(32'h400, 4'hF, 1'b0, 1'b0, 32'h0);
    drain_all();

    // Simultaneous push and pop at count=2, then mixed traffic with wrap.
    store(32'h600, 32'hC0DE0000, 4'hF);
    store(32'h604, 32'hC0DE0001, 4'hF);
    dm_wready = 1'b1;
    store(32'h608, 32'hC0DE0002, 4'hF);
    dm_wready = 1'b0;
    check("pushpop_count", 32'(count), 32'd2);
    model_cnt = 2;
    sv_pat = 10'b1011011111;
    wr_pat = 10'b0110101101;
    for (int i = 0; i < 10; i++) begin
      logic acc;
      logic pp;
      st_valid  = sv_pat[i];
      st_addr   = 32'h700 + 32'(4 * i);
      st_data   = 32'hBEEF0000 + 32'(i);
      st_be     = 4'(i + 1);
      dm_wready = wr_pat[i];
      acc = sv_pat[i] && (model_cnt != DEPTH);
      pp  = wr_pat[i] && (model_cnt != 0);
      if (acc) begin
        drain_t e;
        e.addr = st_addr;
        e.data = st_data;
        e.be   = st_be;
        dq.push_back(e);
      end
      step();
      model_cnt = model_cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
      check("mixed_count", 32'(count), 32'(model_cnt));
    end
    st_valid = 1'b0;
    drain_all();

    // Reset in the middle of a populated buffer discards everything.
    store(32'h800, 32'h80000000, 4'hF);
    store(32'h804, 32'h80000001, 4'hF);
    store(32'h808, 32'h80000002, 4'hF);
    dm_wready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_wvalid", 32'(dm_wvalid), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_st_ready", 32'(st_ready), 32'd1);
    dq.delete();
    dm_wready = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("postrst_count", 32'(count), 32'd0);
    store(32'h900, 32'h90000000, 4'b1010);
    load(32'h900, 4'b1000, 1'b1, 1'b0, 32'h90000000);
    drain_all();

    check("ld_leftover", 32'(lq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
